// File: rtl/dm_pkg.sv
// Shared access-type encodings, response-pipeline entry type and the decode
// helpers used by the data memory bank.
package dm_pkg;

  localparam logic [3:0] LS_W  = 4'b0000;
  localparam logic [3:0] LS_H  = 4'b1000;
  localparam logic [3:0] LS_B  = 4'b0100;
  localparam logic [3:0] LS_HU = 4'b0010;
  localparam logic [3:0] LS_BU = 4'b0001;

  typedef enum logic {ST_INIT, ST_RUN} dm_state_t;

  // Metadata travelling alongside the read word; rd marks a load that returns data.
  typedef struct packed {
    logic       valid;
    logic       err;
    logic       rd;
    logic [3:0] ls;
    logic [1:0] off;
  } rsp_meta_t;

  function automatic logic ls_legal(input logic [3:0] ls);
    case (ls)
      LS_W, LS_H, LS_B, LS_HU, LS_BU: ls_legal = 1'b1;
      default:                        ls_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] be_of(input logic [3:0] ls, input logic [1:0] off);
    case (ls)
      LS_W:         be_of = 4'b1111;
      LS_H, LS_HU:  be_of = 4'b0011 << off;
      LS_B, LS_BU:  be_of = 4'b0001 << off;
      default:      be_of = 4'b0000;
    endcase
  endfunction

  function automatic logic misaligned(input logic [3:0] ls, input logic [1:0] off);
    case (ls)
      LS_W:        misaligned = (off != 2'd0);
      LS_H, LS_HU: misaligned = off[0];
      default:     misaligned = 1'b0;
    endcase
  endfunction

  // Store data is copied onto every lane so the byte enables alone pick the target.
  function automatic logic [31:0] wdata_lanes(input logic [3:0] ls, input logic [31:0] wdata);
    case (ls)
      LS_H, LS_HU: wdata_lanes = {2{wdata[15:0]}};
      LS_B, LS_BU: wdata_lanes = {4{wdata[7:0]}};
      default:     wdata_lanes = wdata;
    endcase
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Load-side lane alignment: shifts the addressed bytes down to bit 0 and
// sign- or zero-extends them according to the access type.
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [3:0]  ls,
  output logic [31:0] rdata
);

  logic [31:0] shifted;

  // NOTE: every output of a combinational block gets a value on every path, so no latch is inferred.
  always_comb begin
    shifted = word >> {off, 3'b000};
    case (ls)
      LS_W:    rdata = shifted;
      LS_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
      LS_HU:   rdata = {16'h0000, shifted[15:0]};
      LS_B:    rdata = {{24{shifted[7]}}, shifted[7:0]};
      LS_BU:   rdata = {24'h000000, shifted[7:0]};
      default: rdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/dm_bank.sv
// Pipelined byte-addressable data memory with valid/ready requests, a fixed
// read latency, lane-aligned sub-word access and a zero-fill sequence after reset.
module dm_bank
  import dm_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 1
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_ls,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);

  dm_state_t     state_q, state_d;
  logic [AW-1:0] init_idx_q, init_idx_d;

  logic          acc;
  logic [AW-1:0] idx;
  logic [1:0]    req_off;
  logic          out_of_range;
  logic          req_err;

  logic [AW-1:0] wr_idx;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data;

  logic [7:0]    lane_mem [4][DEPTH];
  logic [31:0]   word_q   [RD_LAT];
  rsp_meta_t     meta_q   [RD_LAT];
  logic [31:0]   aligned;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    if (state_q == ST_INIT) begin
      init_idx_d = init_idx_q + 1'b1;
      if (init_idx_q == AW'(DEPTH - 1)) state_d = ST_RUN;
    end
  end

  assign req_ready    = (state_q == ST_RUN);
  assign acc          = req_valid & req_ready;
  assign idx          = req_addr[AW+1:2];
  assign req_off      = req_addr[1:0];
  assign out_of_range = |req_addr[31:AW+2];
  assign req_err      = !ls_legal(req_ls) | misaligned(req_ls, req_off) | out_of_range
                      | (req_we & ((req_ls == LS_HU) | (req_ls == LS_BU)));

  // During INIT the write port is borrowed by the zero-fill counter.
  always_comb begin
    wr_idx  = idx;
    wr_be   = 4'b0000;
    wr_data = 32'h0000_0000;
    if (state_q == ST_INIT) begin
      wr_idx = init_idx_q;
      wr_be  = 4'b1111;
    end else if (acc && req_we && !req_err) begin
      wr_be   = be_of(req_ls, req_off);
      wr_data = wdata_lanes(req_ls, req_wdata);
    end
  end

  // NOTE: the memory and data words have no reset; INIT clears the array and valid bits gate the data.
  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (wr_be[l]) lane_mem[l][wr_idx] <= wr_data[8*l +: 8];
    end
    if (acc && !req_we) begin
      for (int l = 0; l < 4; l++) word_q[0][8*l +: 8] <= lane_mem[l][idx];
    end
    for (int k = 1; k < RD_LAT; k++) word_q[k] <= word_q[k-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < RD_LAT; k++) meta_q[k] <= '0;
    end else begin
      meta_q[0] <= '{valid: acc, err: req_err, rd: !req_we && !req_err, ls: req_ls, off: req_off};
      for (int k = 1; k < RD_LAT; k++) meta_q[k] <= meta_q[k-1];
    end
  end

  dm_lane_align u_align (
    .word  (word_q[RD_LAT-1]),
    .off   (meta_q[RD_LAT-1].off),
    .ls    (meta_q[RD_LAT-1].ls),
    .rdata (aligned)
  );

  assign rsp_valid = meta_q[RD_LAT-1].valid;
  assign rsp_err   = meta_q[RD_LAT-1].valid & meta_q[RD_LAT-1].err;
  assign rsp_rdata = (meta_q[RD_LAT-1].valid && meta_q[RD_LAT-1].rd) ? aligned : 32'h0000_0000;

endmodule

// File: tb/tb_dm_bank.sv
// Self-checking bench for dm_bank: byte-array reference model with an in-order
// expected-response queue, directed scenarios pinned by literal values, then random traffic.
module tb_dm_bank;

  localparam int DEPTH  = 16;
  localparam int RD_LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_ls;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  dm_bank #(.DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ls    (req_ls),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
    logic        has_lit;
    logic [31:0] lit_data;
    logic        lit_err;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  mem_m [DEPTH*4];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          nc       = 0;
  int          edges    = 0;
  logic        lit_on   = 1'b0;
  logic [31:0] lit_data = '0;
  logic        lit_err  = 1'b0;
  logic [3:0]  ls_tab [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Reference behaviour: little-endian byte array, access size from the type code.
  function automatic void model_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                                    input logic [3:0] ls, output logic [31:0] rd, output logic err);
    int          size;
    logic        uns;
    logic        legal;
    logic [31:0] v;
    legal = 1'b1;
    uns   = 1'b0;
    size  = 1;
    case (ls)
      4'b0000: size = 4;
      4'b1000: size = 2;
      4'b0100: size = 1;
      4'b0010: begin size = 2; uns = 1'b1; end
      4'b0001: begin size = 1; uns = 1'b1; end
      default: legal = 1'b0;
    endcase
    err = !legal || (addr / 4 >= DEPTH) || (addr % size != 0) || (we && uns);
    rd  = '0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < size; i++) mem_m[int'(addr) + i] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < size; i++) v = v | (32'(mem_m[int'(addr) + i]) << (8*i));
        if (!uns && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
        rd = v;
      end
    end
  endfunction

  always @(posedge clk) begin
    if (rst) edges = 0;
    else     edges = edges + 1;
  end

  always @(negedge clk) begin : cmp
    exp_t        e;
    logic        exp_ready;
    logic [31:0] md;
    logic        me;
    nc++;
    if (rst) begin
      exp_q.delete();
      foreach (mem_m[i]) mem_m[i] = 8'h00;
      check("rst_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_rsp_err", rsp_err, 0);
    end else begin
      exp_ready = (edges >= DEPTH);
      check("req_ready", req_ready, exp_ready);
      if (exp_q.size() > 0 && exp_q[0].due == nc) begin
        e = exp_q.pop_front();
        check("rsp_valid", rsp_valid, 1);
        check("rsp_rdata", rsp_rdata, e.data);
        check("rsp_err", rsp_err, e.err);
        if (e.has_lit) begin
          check("lit_rdata", rsp_rdata, e.lit_data);
          check("lit_err", rsp_err, e.lit_err);
          check("model_vs_lit", e.data, e.lit_data);
        end
      end else begin
        check("idle_rsp_valid", rsp_valid, 0);
        check("idle_rsp_rdata", rsp_rdata, 0);
        check("idle_rsp_err", rsp_err, 0);
      end
      if (req_valid && exp_ready) begin
        model_req(req_we, req_addr, req_wdata, req_ls, md, me);
        e = '{due: nc + RD_LAT, data: md, err: me, has_lit: lit_on, lit_data: lit_data, lit_err: lit_err};
        exp_q.push_back(e);
      end
    end
  end

  // Called at posedge+1; holds the request for exactly one accept edge.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] ls, input logic [31:0] exp_d, input logic exp_e);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_ls    = ls;
    lit_on    = 1'b1;
    lit_data  = exp_d;
    lit_err   = exp_e;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lit_on    = 1'b0;
  endtask

  task automatic wait_ready();
    int cnt = 0;
    while (cnt < 200) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (req_ready) break;
    end
    check("init_edges", cnt, DEPTH);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    repeat (RD_LAT + 2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_ls    = '0;
    ls_tab[0] = 4'b0000; ls_tab[1] = 4'b1000; ls_tab[2] = 4'b0100;
    ls_tab[3] = 4'b0010; ls_tab[4] = 4'b0001; ls_tab[5] = 4'b1100;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    wait_ready();

    issue(1'b0, 32'h3C, 32'h0, 4'b0000, 32'h0000_0000, 1'b0);

    issue(1'b1, 32'h10, 32'h8001_7FFF, 4'b0000, 32'h0, 1'b0);
    issue(1'b0, 32'h10, 32'h0, 4'b0000, 32'h8001_7FFF, 1'b0);
    issue(1'b0, 32'h12, 32'h0, 4'b1000, 32'hFFFF_8001, 1'b0);
    issue(1'b0, 32'h12, 32'h0, 4'b0010, 32'h0000_8001, 1'b0);
    issue(1'b0, 32'h10, 32'h0, 4'b0100, 32'hFFFF_FFFF, 1'b0);
    issue(1'b0, 32'h11, 32'h0, 4'b0001, 32'h0000_007F, 1'b0);

    issue(1'b1, 32'h21, 32'h0000_00A5, 4'b0100, 32'h0, 1'b0);
    issue(1'b0, 32'h20, 32'h0, 4'b0000, 32'h0000_A500, 1'b0);

    issue(1'b1, 32'h04, 32'h1122_3344, 4'b0000, 32'h0, 1'b0);
    issue(1'b0, 32'h02, 32'h0, 4'b0000, 32'h0, 1'b1);
    issue(1'b0, 32'h04, 32'h0, 4'b0000, 32'h1122_3344, 1'b0);
    issue(1'b1, 32'h03, 32'hBEEF, 4'b1000, 32'h0, 1'b1);
    issue(1'b0, 32'h04, 32'h0, 4'b0000, 32'h1122_3344, 1'b0);
    issue(1'b1, 32'h04, 32'hFF, 4'b0001, 32'h0, 1'b1);
    issue(1'b0, 32'h04, 32'h0, 4'b0000, 32'h1122_3344, 1'b0);
    issue(1'b0, 32'(4*DEPTH), 32'h0, 4'b0000, 32'h0, 1'b1);
    issue(1'b0, 32'h04, 32'h0, 4'b0000, 32'h1122_3344, 1'b0);
    drain();

    issue(1'b0, 32'h00, 32'h0, 4'b0000, 32'h0000_0000, 1'b0);
    issue(1'b0, 32'h04, 32'h0, 4'b0000, 32'h1122_3344, 1'b0);
    issue(1'b0, 32'h10, 32'h0, 4'b0000, 32'h8001_7FFF, 1'b0);
    issue(1'b0, 32'h20, 32'h0, 4'b0000, 32'h0000_A500, 1'b0);
    issue(1'b0, 32'h3C, 32'h0, 4'b0000, 32'h0000_0000, 1'b0);
    drain();

    issue(1'b0, 32'h10, 32'h0, 4'b0000, 32'h8001_7FFF, 1'b0);
    issue(1'b0, 32'h14, 32'h0, 4'b0000, 32'h0000_0000, 1'b0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    wait_ready();
    issue(1'b0, 32'h10, 32'h0, 4'b0000, 32'h0000_0000, 1'b0);
    drain();

    for (int n = 0; n < 400; n++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_we    = 1'($urandom_range(0, 1));
      req_ls    = ls_tab[$urandom_range(0, 5)];
      case ($urandom_range(0, 7))
        0:       req_addr = $urandom();
        1:       req_addr = 32'(4*DEPTH) + 32'($urandom_range(0, 15));
        default: req_addr = 32'($urandom_range(0, 4*DEPTH - 1));
      endcase
      req_wdata = $urandom();
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    drain();

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
